// File: rtl/cnt_seq_ctrl_if.sv
// Command/response channel between a command source and the counter sequencer.
interface cnt_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [LEN_W-1:0] cmd_len;
  logic             done;
  logic [WIDTH-1:0] rsp_count;
  logic [LEN_W-1:0] rsp_wraps;
  logic             rsp_aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_len,
    input  cmd_ready, done, rsp_count, rsp_wraps, rsp_aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_len,
    output cmd_ready, done, rsp_count, rsp_wraps, rsp_aborted
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Sequencer for counter_ud: runs LOAD/UP/DOWN/HOLD commands for an exact number
// of cycles and freezes the counter between commands by reloading its value.
module cnt_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  cnt_seq_ctrl_if.slave    cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             load_en,
  output logic [WIDTH-1:0] load,
  output logic             down,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_UP, OP_DOWN, OP_HOLD} op_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_down;
  logic [WIDTH-1:0] r_arg;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_wraps;
  logic [WIDTH-1:0] r_rsp_count;
  logic [LEN_W-1:0] r_rsp_wraps;
  logic             r_rsp_aborted;

  op_t              w_op;
  logic             w_wrap;
  logic             w_last;
  logic [WIDTH-1:0] w_step;
  logic [LEN_W-1:0] w_wraps_nxt;

  assign w_op        = op_t'(cmd.cmd_op);
  assign w_wrap      = r_down ? (count == '0) : (count == '1);
  assign w_last      = (r_len == LEN_W'(1)) || abort;
  assign w_step      = r_down ? count - WIDTH'(1) : count + WIDTH'(1);
  assign w_wraps_nxt = r_wraps + LEN_W'(w_wrap);

  // Counter has no enable: every non-RUN state reloads it (LOAD with the argument).
  assign load_en = (r_state != S_RUN);
  assign load    = (r_state == S_LOAD) ? r_arg : count;
  assign down    = r_down;
  assign busy    = r_busy;

  assign cmd.cmd_ready   = r_ready;
  assign cmd.done        = r_done;
  assign cmd.rsp_count   = r_rsp_count;
  assign cmd.rsp_wraps   = r_rsp_wraps;
  assign cmd.rsp_aborted = r_rsp_aborted;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_down        <= 1'b0;
      r_arg         <= '0;
      r_len         <= '0;
      r_wraps       <= '0;
      r_rsp_count   <= '0;
      r_rsp_wraps   <= '0;
      r_rsp_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            r_arg   <= cmd.cmd_arg;
            r_len   <= cmd.cmd_len;
            r_wraps <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_op == OP_LOAD) begin
              r_state <= S_LOAD;
            end else if (cmd.cmd_len == '0) begin
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_rsp_count   <= count;
              r_rsp_wraps   <= '0;
              r_rsp_aborted <= 1'b0;
            end else if (w_op == OP_HOLD) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_RUN;
              r_down  <= (w_op == OP_DOWN);
            end
          end
        end
        S_LOAD: begin
          r_state       <= S_DONE;
          r_done        <= 1'b1;
          r_rsp_count   <= r_arg;
          r_rsp_wraps   <= '0;
          r_rsp_aborted <= 1'b0;
        end
        S_RUN: begin
          r_wraps <= w_wraps_nxt;
          // Response captures the post-step value the counter settles to in DONE.
          if (w_last) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_rsp_count   <= w_step;
            r_rsp_wraps   <= w_wraps_nxt;
            r_rsp_aborted <= abort;
          end else begin
            r_len <= r_len - LEN_W'(1);
          end
        end
        S_HOLD: begin
          if (w_last) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_rsp_count   <= count;
            r_rsp_wraps   <= '0;
            r_rsp_aborted <= abort;
          end else begin
            r_len <= r_len - LEN_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl with a behavioural counter_ud closing the loop.
module tb_cnt_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] count;
  logic             load_en;
  logic [WIDTH-1:0] load;
  logic             down;
  logic             busy;

  int checks = 0;
  int errors = 0;

  cnt_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) cif ();

  cnt_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cmd     (cif.slave),
    .abort   (abort),
    .count   (count),
    .load_en (load_en),
    .load    (load),
    .down    (down),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // counter_ud model
  always @(posedge clk or negedge rstn) begin
    if (!rstn)        count <= '0;
    else if (load_en) count <= load;
    else if (down)    count <= count - 4'd1;
    else              count <= count + 4'd1;
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] arg;
    logic [7:0] len;
    int         abort_at;
    logic [3:0] e_cnt;
    logic [7:0] e_wraps;
    logic       e_ab;
    int         e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] arg, input logic [7:0] len);
    int n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_issue", 32'(cif.cmd_ready), 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    cif.cmd_len   = len;
    tick();
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b11;
    cif.cmd_arg   = 4'hF;
    cif.cmd_len   = 8'hFF;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 1;
    bit got = 0;
    issue(v.op, v.arg, v.len);
    while (lat <= 300) begin
      abort = (lat == v.abort_at);
      if (lat == 1) check($sformatf("v%0d_busy", idx), 32'(busy), 1);
      if (v.op == 2'b00 && lat == 1) begin
        check($sformatf("v%0d_load_en", idx), 32'(load_en), 1);
        check($sformatf("v%0d_load", idx), 32'(load), 32'(v.arg));
      end
      if ((v.op == 2'b01 || v.op == 2'b10) && v.len != 0 && lat == 1) begin
        check($sformatf("v%0d_run_load_en", idx), 32'(load_en), 0);
        check($sformatf("v%0d_down", idx), 32'(down), 32'(v.op == 2'b10));
      end
      if (cif.done === 1'b1) begin
        got = 1;
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.e_lat));
        check($sformatf("v%0d_rsp_count", idx), 32'(cif.rsp_count), 32'(v.e_cnt));
        check($sformatf("v%0d_rsp_wraps", idx), 32'(cif.rsp_wraps), 32'(v.e_wraps));
        check($sformatf("v%0d_rsp_aborted", idx), 32'(cif.rsp_aborted), 32'(v.e_ab));
        check($sformatf("v%0d_count", idx), 32'(count), 32'(v.e_cnt));
        break;
      end
      tick();
      lat++;
    end
    abort = 1'b0;
    if (!got) check($sformatf("v%0d_done_timeout", idx), 0, 1);
    tick();
    check($sformatf("v%0d_done_one_cycle", idx), 32'(cif.done), 0);
    check($sformatf("v%0d_ready_after", idx), 32'(cif.cmd_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cif.cmd_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(cif.done), 0);
    check({tag, "_down"}, 32'(down), 0);
    check({tag, "_load_en"}, 32'(load_en), 1);
    check({tag, "_rsp_count"}, 32'(cif.rsp_count), 0);
    check({tag, "_rsp_wraps"}, 32'(cif.rsp_wraps), 0);
    check({tag, "_rsp_aborted"}, 32'(cif.rsp_aborted), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] base;
    //               op     arg   len   ab  cnt   wr    ab  lat
    vecs[0]  = '{2'b00, 4'hA, 8'd0,   0, 4'hA, 8'd0, 0,  2};
    vecs[1]  = '{2'b01, 4'h0, 8'd9,   0, 4'h3, 8'd1, 0, 10};
    vecs[2]  = '{2'b10, 4'h0, 8'd20,  0, 4'hF, 8'd2, 0, 21};
    vecs[3]  = '{2'b00, 4'h0, 8'd0,   0, 4'h0, 8'd0, 0,  2};
    vecs[4]  = '{2'b01, 4'h0, 8'd100, 4, 4'h4, 8'd0, 1,  5};
    vecs[5]  = '{2'b01, 4'h0, 8'd3,   3, 4'h7, 8'd0, 1,  4};
    vecs[6]  = '{2'b11, 4'h0, 8'd2,   1, 4'h7, 8'd0, 1,  2};
    vecs[7]  = '{2'b10, 4'h0, 8'd8,   0, 4'hF, 8'd1, 0,  9};
    vecs[8]  = '{2'b01, 4'h0, 8'd1,   0, 4'h0, 8'd1, 0,  2};
    vecs[9]  = '{2'b11, 4'h0, 8'd0,   0, 4'h0, 8'd0, 0,  1};
    vecs[10] = '{2'b00, 4'hC, 8'd0,   0, 4'hC, 8'd0, 0,  2};

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_arg   = '0;
    cif.cmd_len   = '0;

    // Reset and idle freeze
    #12;
    check_reset_outputs("in_reset");
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ready", 32'(cif.cmd_ready), 1);
      check("idle_load_en", 32'(load_en), 1);
      check("idle_load_tracks", 32'(load), 32'(count));
      check("idle_count", 32'(count), 0);
      check("idle_done", 32'(cif.done), 0);
    end

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-to-back: UP len0 then HOLD len5 with cmd_valid held high
    base = count;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'b01;
    cif.cmd_len   = 8'd0;
    tick();
    cif.cmd_op  = 2'b11;
    cif.cmd_len = 8'd5;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) cif.cmd_valid = 1'b0;
      check($sformatf("b2b_done_k%0d", k), 32'(cif.done), 32'(k == 1 || k == 8));
      check($sformatf("b2b_count_k%0d", k), 32'(count), 32'(base));
      if (k == 2) check("b2b_ready_idle", 32'(cif.cmd_ready), 1);
      if (k >= 3 && k <= 8) check($sformatf("b2b_busy_k%0d", k), 32'(busy), 1);
      if (k == 1 || k == 8) begin
        check($sformatf("b2b_rsp_count_k%0d", k), 32'(cif.rsp_count), 32'(base));
        check($sformatf("b2b_rsp_wraps_k%0d", k), 32'(cif.rsp_wraps), 0);
        check($sformatf("b2b_rsp_ab_k%0d", k), 32'(cif.rsp_aborted), 0);
      end
      tick();
    end

    // Reset asserted mid-RUN
    issue(2'b01, 4'h0, 8'd50);
    for (int k = 0; k < 5; k++) tick();
    check("midrun_busy", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_no_done", 32'(cif.done), 0);
      check("reset_busy", 32'(busy), 0);
    end
    rstn = 1'b1;
    tick();
    check("post_reset_ready", 32'(cif.cmd_ready), 1);
    check("post_reset_done", 32'(cif.done), 0);
    run_vec('{2'b00, 4'h5, 8'd0, 0, 4'h5, 8'd0, 0, 2}, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
Command-driven sequencer for the up/down counter (counter_ud). It accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and drives the counter's load_en, load and down controls. It steps the counter an exact number of cycles, tracks wrap-arounds, and returns a one-cycle completion response. Between commands it freezes the counter, which has no enable, by reloading its current value every cycle.

Parameters:
WIDTH, 4, counter width; must match counter_ud.
LEN_W, 8, width of the step/cycle count field cmd_len.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command; high only in IDLE.
cmd_op  input  2  operation: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
cmd_arg  input  WIDTH  load value; used by LOAD only.
cmd_len  input  LEN_W  step count (UP/DOWN) or freeze cycles (HOLD).
abort  input  1  terminate current UP/DOWN/HOLD early.
count  input  WIDTH  counter_ud count output.
load_en  output  1  to counter_ud load_en.
load  output  WIDTH  to counter_ud load.
down  output  1  to counter_ud down.
busy  output  1  high in LOAD/RUN/HOLD/DONE.
done  output  1  one-cycle completion pulse.
rsp_count  output  WIDTH  counter value at completion; valid with done.
rsp_wraps  output  LEN_W  wraps during command; valid with done.
rsp_aborted  output  1  command ended by abort; valid with done.

Behaviour:
- counter_ud contract: on each rising clk, loads load if load_en=1; otherwise count becomes count+1 (down=0) or count-1 (down=1), mod 2^WIDTH.
- States: IDLE, LOAD, RUN, HOLD, DONE.
- Freeze in IDLE, HOLD and DONE: load_en=1 and load=count. This is a combinational path from count to load. The counter holds its value.
- Reset (async, rstn=0): state=IDLE, down=0, done=0, busy=0, rsp_count=0, rsp_wraps=0, rsp_aborted=0, internal length/wrap counters=0. Outputs follow immediately, not at the next edge. A reset in any state abandons the command silently and produces no done.
- Accept: cmd_valid&cmd_ready at rising edge T latches op, arg and len, and clears the wrap counter and aborted flag. Call the accept edge cycle T.
- IDLE→LOAD (op LOAD): cycle T+1 drives load_en=1, load=cmd_arg. Then DONE at T+2 with rsp_count=cmd_arg.
- IDLE→RUN (op UP/DOWN, len≥1): cycles T+1..T+len drive load_en=0, down=(op==DOWN). Exactly len steps. Then DONE at T+len+1.
- IDLE→HOLD (op HOLD, len≥1): frozen for len cycles, then DONE at T+len+1.
- len=0 with UP/DOWN/HOLD: go straight to DONE at T+1. Count is unchanged and wraps=0.
- down holds its value outside RUN, i.e. the last commanded direction is kept.
- Wrap detect, RUN cycles only: a wrap is (!down && count==2^WIDTH-1) || (down && count==0). The controller computes it from count, not from counter rollover. rsp_wraps increments on each wrap and cannot overflow, since wraps ≤ len.
- DONE: exactly one cycle. done=1, rsp_count=count (the settled value), rsp_wraps and rsp_aborted valid. Counter frozen. Next state IDLE; cmd_ready=0 in this cycle.
- Back-to-back commands: a command held valid during DONE is accepted on the following IDLE edge. Max rate is one command per len+2 cycles.
- abort sampled high in a RUN/HOLD cycle:
  - that cycle still steps (RUN) or freezes (HOLD);
  - next state is DONE with rsp_aborted=1;
  - abort coinciding with the final len cycle still sets rsp_aborted=1.
- abort in IDLE/LOAD/DONE is ignored.
- cmd_op, cmd_arg and cmd_len are ignored except on the accept edge.

Test Plan:
(WIDTH=4, LEN_W=8)
1. Reset release, no commands: cmd_ready=1, load_en=1, load tracks count, count frozen at 0 for 20 cycles; done never pulses.
2. LOAD arg=0xA accepted at T: load_en=1/load=0xA at T+1; done at T+2 with rsp_count=0xA, rsp_wraps=0, rsp_aborted=0.
3. From 0xA, UP len=9: done at T+10, rsp_count=0x3, rsp_wraps=1. Then DOWN len=20: done at T+21, rsp_count=0xF, rsp_wraps=2.
4. UP len=0: done at T+1, count unchanged, wraps 0. Then HOLD len=5: done at T+6, count unchanged across all 6 cycles. Also hold cmd_valid continuously with both commands queued: both accepted, no overlap.
5. From 0x0, UP len=100, abort high in the 4th RUN cycle: done the next cycle, rsp_count=0x4, rsp_aborted=1, rsp_wraps=0.
6. rstn pulsed low mid-RUN (UP len=50): all outputs at reset values immediately, no done. cmd_ready=1 after release; the next LOAD 0x5 completes normally.
